// File: rtl/player_controller.sv
// player_controller: turns debounced pad inputs into a registered player position, facing,
// sword hitbox and health; movement, attack and invulnerability timers advance on the frame tick.
module player_controller #(
  parameter int X_BITS       = 4,
  parameter int Y_BITS       = 4,
  parameter int X_MAX        = 15,
  parameter int Y_MAX        = 11,
  parameter int START_X      = 0,
  parameter int START_Y      = 0,
  parameter int MOVE_TICKS   = 4,
  parameter int ATTACK_TICKS = 8,
  parameter int HEALTH_BITS  = 2,
  parameter int MAX_HEALTH   = 3,
  parameter int INVULN_TICKS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   up,
  input  logic                   down,
  input  logic                   left,
  input  logic                   right,
  input  logic                   A,
  input  logic                   B,
  input  logic                   start,
  input  logic                   hit,
  output logic [X_BITS-1:0]      player_x,
  output logic [Y_BITS-1:0]      player_y,
  output logic [1:0]             player_dir,
  output logic [X_BITS-1:0]      sword_x,
  output logic [Y_BITS-1:0]      sword_y,
  output logic                   sword_valid,
  output logic [HEALTH_BITS-1:0] player_health,
  output logic                   invuln,
  output logic                   dead
);

  typedef enum logic [1:0] {IDLE, MOVE, ATTACK, DEAD} state_t;

  localparam int CNT_MAX = (MOVE_TICKS > ATTACK_TICKS) ? MOVE_TICKS : ATTACK_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int INV_W   = $clog2(INVULN_TICKS + 1);

  localparam logic [X_BITS-1:0]      X_MAX_C   = X_BITS'(X_MAX);
  localparam logic [Y_BITS-1:0]      Y_MAX_C   = Y_BITS'(Y_MAX);
  localparam logic [X_BITS-1:0]      START_X_C = X_BITS'(START_X);
  localparam logic [Y_BITS-1:0]      START_Y_C = Y_BITS'(START_Y);
  localparam logic [HEALTH_BITS-1:0] HEALTH_C  = HEALTH_BITS'(MAX_HEALTH);
  localparam logic [CNT_W-1:0]       MOVE_LOAD = CNT_W'(MOVE_TICKS - 1);
  localparam logic [CNT_W-1:0]       ATK_LOAD  = CNT_W'(ATTACK_TICKS - 1);
  localparam logic [INV_W-1:0]       INV_LOAD  = INV_W'(INVULN_TICKS);

  typedef struct packed {
    logic              ok;
    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
  } cell_t;

  // Adjacent cell in direction d; when off-grid, ok=0 and the cell is the origin itself.
  function automatic cell_t neighbour(input logic [1:0] d, input logic [X_BITS-1:0] cx,
                                      input logic [Y_BITS-1:0] cy);
    cell_t c;
    c.ok = 1'b0;
    c.x  = cx;
    c.y  = cy;
    case (d)
      2'b00: if (cy != '0) begin c.ok = 1'b1; c.y = cy - Y_BITS'(1); end
      2'b01: if (cy < Y_MAX_C) begin c.ok = 1'b1; c.y = cy + Y_BITS'(1); end
      2'b10: if (cx != '0) begin c.ok = 1'b1; c.x = cx - X_BITS'(1); end
      default: if (cx < X_MAX_C) begin c.ok = 1'b1; c.x = cx + X_BITS'(1); end
    endcase
    return c;
  endfunction

  state_t                 state_q;
  logic [X_BITS-1:0]      x_q, sword_x_q;
  logic [Y_BITS-1:0]      y_q, sword_y_q;
  logic [1:0]             dir_q;
  logic                   sword_valid_q;
  logic [HEALTH_BITS-1:0] health_q;
  logic [INV_W-1:0]       inv_cnt_q;
  logic                   invuln_q;
  logic                   dead_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   pend_q;
  logic                   ab_q;

  logic       ab_d, rise, dir_vld, hit_ok, dying;
  logic [1:0] dir_new;
  cell_t      mv, sw;

  always_comb begin
    dir_new = 2'b00;
    if (down)       dir_new = 2'b01;
    else if (left)  dir_new = 2'b10;
    else if (right) dir_new = 2'b11;
  end

  assign dir_vld = $onehot({up, down, left, right});
  assign ab_d    = A | B;
  assign rise    = ab_d & ~ab_q;
  assign mv      = neighbour(dir_new, x_q, y_q);
  assign sw      = neighbour(dir_q, x_q, y_q);
  assign hit_ok  = hit & ~invuln_q & (state_q != DEAD);
  assign dying   = hit_ok & (health_q == HEALTH_BITS'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      x_q           <= START_X_C;
      y_q           <= START_Y_C;
      dir_q         <= 2'b00;
      sword_x_q     <= START_X_C;
      sword_y_q     <= START_Y_C;
      sword_valid_q <= 1'b0;
      health_q      <= HEALTH_C;
      inv_cnt_q     <= '0;
      invuln_q      <= 1'b0;
      dead_q        <= 1'b0;
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      ab_q          <= 1'b0;
    end else begin
      ab_q <= ab_d;
      if (state_q == DEAD) begin
        if (start) begin
          state_q       <= IDLE;
          x_q           <= START_X_C;
          y_q           <= START_Y_C;
          dir_q         <= 2'b00;
          sword_x_q     <= START_X_C;
          sword_y_q     <= START_Y_C;
          sword_valid_q <= 1'b0;
          health_q      <= HEALTH_C;
          inv_cnt_q     <= '0;
          invuln_q      <= 1'b0;
          dead_q        <= 1'b0;
          cnt_q         <= '0;
          pend_q        <= 1'b0;
        end
      end else if (dying) begin
        // Fatal damage wins over anything the tick would otherwise start this cycle.
        state_q       <= DEAD;
        health_q      <= '0;
        sword_valid_q <= 1'b0;
        inv_cnt_q     <= '0;
        invuln_q      <= 1'b0;
        dead_q        <= 1'b1;
        cnt_q         <= '0;
        pend_q        <= 1'b0;
      end else begin
        if (hit_ok) begin
          health_q  <= health_q - HEALTH_BITS'(1);
          inv_cnt_q <= INV_LOAD;
          invuln_q  <= 1'b1;
        end else if (tick && (inv_cnt_q != '0)) begin
          inv_cnt_q <= inv_cnt_q - INV_W'(1);
          invuln_q  <= (inv_cnt_q != INV_W'(1));
        end
        pend_q <= pend_q | rise;
        if (tick) begin
          case (state_q)
            IDLE: begin
              if (pend_q) begin
                state_q       <= ATTACK;
                cnt_q         <= ATK_LOAD;
                pend_q        <= rise;
                sword_valid_q <= sw.ok;
                sword_x_q     <= sw.x;
                sword_y_q     <= sw.y;
              end else if (dir_vld) begin
                dir_q <= dir_new;
                if (mv.ok) begin
                  x_q <= mv.x;
                  y_q <= mv.y;
                  if (MOVE_TICKS > 1) begin
                    state_q <= MOVE;
                    cnt_q   <= MOVE_LOAD;
                  end
                end
              end
            end
            MOVE: begin
              cnt_q <= cnt_q - CNT_W'(1);
              if (cnt_q <= CNT_W'(1)) state_q <= IDLE;
            end
            ATTACK: begin
              if (cnt_q <= CNT_W'(1)) begin
                state_q       <= IDLE;
                cnt_q         <= '0;
                sword_valid_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q - CNT_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign player_x      = x_q;
  assign player_y      = y_q;
  assign player_dir    = dir_q;
  assign sword_x       = sword_x_q;
  assign sword_y       = sword_y_q;
  assign sword_valid   = sword_valid_q;
  assign player_health = health_q;
  assign invuln        = invuln_q;
  assign dead          = dead_q;

endmodule

// File: tb/tb_player_controller.sv
// Scoreboard bench for player_controller: stimulus updates a behavioural model and queues the
// expected outputs; a monitor pops one entry per clock edge (and per async reset) and compares.
module tb_player_controller;

  localparam int XM = 15, YM = 11, SX = 0, SY = 0;
  localparam int MT = 4, AT = 8, HM = 3, IT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 0, up = 0, down = 0, left = 0, right = 0, A = 0, B = 0, start = 0, hit = 0;
  logic [3:0] player_x, sword_x;
  logic [3:0] player_y, sword_y;
  logic [1:0] player_dir, player_health;
  logic       sword_valid, invuln, dead;

  player_controller #(
    .X_BITS(4), .Y_BITS(4), .X_MAX(XM), .Y_MAX(YM), .START_X(SX), .START_Y(SY),
    .MOVE_TICKS(MT), .ATTACK_TICKS(AT), .HEALTH_BITS(2), .MAX_HEALTH(HM), .INVULN_TICKS(IT)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .up(up), .down(down), .left(left), .right(right),
    .A(A), .B(B), .start(start), .hit(hit),
    .player_x(player_x), .player_y(player_y), .player_dir(player_dir),
    .sword_x(sword_x), .sword_y(sword_y), .sword_valid(sword_valid),
    .player_health(player_health), .invuln(invuln), .dead(dead)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x, y, dir, sx, sy, sv, hp, inv, dead;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 0;

  // Behavioural model: mode 0 standing, 1 cooling down after a step, 2 swinging, 3 dead.
  int mx, my, mdir, msx, msy, msv, mhp, minv, mdead, mmode, mtimer, mpend, mab;
  int DX[4] = '{0, 0, -1, 1};
  int DY[4] = '{-1, 1, 0, 0};

  function automatic bit on_grid(int x, int y);
    return (x >= 0) && (x <= XM) && (y >= 0) && (y <= YM);
  endfunction

  function automatic void model_reset(bit keep_ab);
    mx = SX; my = SY; mdir = 0; msx = SX; msy = SY; msv = 0;
    mhp = HM; minv = 0; mdead = 0; mmode = 0; mtimer = 0; mpend = 0;
    if (!keep_ab) mab = 0;
  endfunction

  function automatic void model_step(bit t, bit [3:0] dirs, bit a, bit b, bit s, bit h);
    int want, nx, ny, was_pending;
    bit edge_ab;
    want = -1;
    if (dirs[3] + dirs[2] + dirs[1] + dirs[0] == 1)
      want = dirs[3] ? 0 : dirs[2] ? 1 : dirs[1] ? 2 : 3;
    edge_ab = (a | b) && (mab == 0);
    mab = a | b;
    if (mmode == 3) begin
      if (s) model_reset(1);
      return;
    end
    if (h && minv == 0 && mhp == 1) begin
      mhp = 0; mmode = 3; msv = 0; minv = 0; mdead = 1; mpend = 0; mtimer = 0;
      return;
    end
    was_pending = mpend;
    if (h && minv == 0) begin
      mhp = mhp - 1;
      minv = IT;
    end else if (t && minv > 0) begin
      minv = minv - 1;
    end
    if (edge_ab) mpend = 1;
    if (!t) return;
    if (mmode == 0) begin
      if (was_pending) begin
        mmode = 2; mtimer = AT - 1; mpend = edge_ab;
        nx = mx + DX[mdir]; ny = my + DY[mdir];
        if (on_grid(nx, ny)) begin msv = 1; msx = nx; msy = ny; end
        else begin msv = 0; msx = mx; msy = my; end
      end else if (want >= 0) begin
        mdir = want;
        nx = mx + DX[want]; ny = my + DY[want];
        if (on_grid(nx, ny)) begin
          mx = nx; my = ny;
          if (MT > 1) begin mmode = 1; mtimer = MT - 1; end
        end
      end
    end else if (mmode == 1) begin
      mtimer = mtimer - 1;
      if (mtimer <= 0) mmode = 0;
    end else begin
      mtimer = mtimer - 1;
      if (mtimer <= 0) begin mmode = 0; msv = 0; mtimer = 0; end
    end
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    e.x = mx; e.y = my; e.dir = mdir; e.sx = msx; e.sy = msy; e.sv = msv;
    e.hp = mhp; e.inv = (minv != 0); e.dead = mdead;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    wait (mon_en);
    forever begin
      @(posedge clk or negedge reset);
      #1;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty at %0t: got no expectation, expected one queued", $time);
      end else begin
        e = exp_q.pop_front();
        check("player_x", int'(player_x), e.x);
        check("player_y", int'(player_y), e.y);
        check("player_dir", int'(player_dir), e.dir);
        check("sword_x", int'(sword_x), e.sx);
        check("sword_y", int'(sword_y), e.sy);
        check("sword_valid", int'(sword_valid), e.sv);
        check("player_health", int'(player_health), e.hp);
        check("invuln", int'(invuln), e.inv);
        check("dead", int'(dead), e.dead);
      end
    end
  end

  // Called at a negedge; drives one cycle of inputs and returns at the next negedge.
  task automatic cyc(input bit t, input bit [3:0] dirs, input bit a, input bit b,
                     input bit s, input bit h);
    tick = t; {up, down, left, right} = dirs; A = a; B = b; start = s; hit = h;
    model_step(t, dirs, a, b, s, h);
    exp_q.push_back(cur_exp());
    @(negedge clk);
  endtask

  task automatic hold(input int n, input int per, input bit [3:0] dirs);
    for (int i = 0; i < n; i++) cyc((i % per) == per - 1, dirs, 0, 0, 0, 0);
  endtask

  // Asynchronous reset dropped between clock edges, held for 'cycles' rising edges.
  task automatic do_reset(input int cycles);
    tick = 0; {up, down, left, right} = 4'b0; A = 0; B = 0; start = 0; hit = 0;
    model_reset(0);
    exp_q.push_back(cur_exp());
    mon_en = 1;
    #2 reset = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      exp_q.push_back(cur_exp());
      @(negedge clk);
    end
    reset = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit [3:0] dirs;
    int r;
    @(negedge clk);
    do_reset(2);

    hold(32, 4, 4'b0001);            // right for 8 ticks
    hold(8, 4, 4'b0000);
    hold(4, 4, 4'b1000);             // up at the top edge
    hold(4, 4, 4'b1100);             // up+down: no direction
    cyc(0, 4'b0, 1, 0, 0, 0);        // attack facing up at y=0
    hold(40, 4, 4'b0000);
    hold(4, 4, 4'b0001);
    hold(16, 4, 4'b0000);
    cyc(0, 4'b0, 1, 1, 0, 0);        // A+B together
    hold(40, 4, 4'b0000);

    cyc(0, 4'b0, 0, 0, 0, 1);        // hit, then a second hit 3 clk later
    hold(2, 100, 4'b0000);
    cyc(0, 4'b0, 0, 0, 0, 1);
    hold(70, 4, 4'b0000);
    cyc(1, 4'b0001, 0, 0, 0, 1);     // hit on a tick cycle with movement
    hold(70, 4, 4'b0000);
    cyc(0, 4'b0, 1, 0, 0, 0);
    cyc(1, 4'b0001, 0, 0, 0, 1);     // fatal hit on a tick with pending attack
    hold(12, 4, 4'b0001);
    cyc(0, 4'b0, 1, 0, 0, 1);
    cyc(0, 4'b0, 0, 0, 1, 0);        // respawn
    hold(8, 4, 4'b0000);

    hold(8, 4, 4'b0010);
    cyc(0, 4'b0, 0, 1, 0, 0);
    hold(10, 4, 4'b0000);
    do_reset(1);                     // reset in the middle of an attack
    hold(8, 4, 4'b0100);

    dirs = 4'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 8 == 0) begin
        r = $urandom_range(0, 9);
        dirs = (r < 6) ? (4'b0001 << (r % 4)) : ((r < 8) ? 4'b0000 : 4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 499) == 0) begin
        do_reset(1);
      end else begin
        cyc($urandom_range(0, 2) == 0, dirs, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 39) == 0);
      end
    end

    #2;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
